wb_ram_arbiter: RTL

//  Shares one single-port byte-masked RAM macro among three requesters: SERV ibus, SERV dbus, and
//  a host byte port driven from the pins. Arbitrates, sequences the macro access and returns data
//  and an ack to the winning requester. Sits between serv_top and the RAM instance in the
//  tt_um top level.

---
 rtl/wb_ram_pkg.sv | 40 ++++
 rtl/wb_ram_arbiter_if.sv | 66 ++++++
 rtl/wb_ram_grant.sv | 41 ++++
 rtl/wb_ram_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/wb_ram_pkg.sv
// Package shared by the wb_ram_arbiter block.
// Contents:
//   state_e   - sequencer states IDLE -> ISSUE -> WAIT -> DONE
//   grant_e   - requester encoding, also the bit index into request/grant vectors
//   N_REQ     - number of requesters
//   BYTE_W    - byte-lane width
//   lane_bits - number of address bits that select a byte lane for a data width
//   next_grant- round-robin successor (host -> dbus -> ibus -> host)
package wb_ram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    G_HOST = 2'd0,
    G_DBUS = 2'd1,
    G_IBUS = 2'd2
  } grant_e;

  localparam int unsigned N_REQ  = 3;
  localparam int unsigned BYTE_W = 8;

  // Lane-select width; the data width must hold at least two byte lanes.
  function automatic int unsigned lane_bits(int unsigned dw);
    return $clog2(dw / BYTE_W);
  endfunction

  function automatic grant_e next_grant(grant_e g);
    case (g)
      G_HOST:  return G_DBUS;
      G_DBUS:  return G_IBUS;
      default: return G_HOST;
    endcase
  endfunction

endpackage

// File: rtl/wb_ram_arbiter_if.sv
// Bus bundle between the three requesters (SERV ibus, SERV dbus, host byte
// port), the arbiter and the single-port RAM macro.
// Modports:
//   slave  - arbiter view: request inputs and RAM read data in, responses and
//            RAM controls out
//   master - environment view (requesters + RAM), the mirror image
// Parameters: DW data width (multiple of 8), AW RAM word-address bits.
interface wb_ram_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  import wb_ram_pkg::*;

  localparam int NB = DW / 8;
  localparam int LB = lane_bits(DW);

  // SERV instruction bus
  logic          i_ibus_cyc;
  logic [31:0]   i_ibus_adr;
  logic [DW-1:0] o_ibus_rdt;
  logic          o_ibus_ack;
  // SERV data bus
  logic          i_dbus_cyc;
  logic [31:0]   i_dbus_adr;
  logic          i_dbus_we;
  logic [DW-1:0] i_dbus_dat;
  logic [NB-1:0] i_dbus_sel;
  logic [DW-1:0] o_dbus_rdt;
  logic          o_dbus_ack;
  // Host byte port
  logic             i_h_valid;
  logic             i_h_we;
  logic [AW+LB-1:0] i_h_addr;
  logic [7:0]       i_h_wdata;
  logic [7:0]       o_h_rdata;
  logic             o_h_ready;
  // RAM macro
  logic          o_ram_en;
  logic [AW-1:0] o_ram_a;
  logic [NB-1:0] o_ram_we;
  logic [DW-1:0] o_ram_di;
  logic [DW-1:0] i_ram_do;

  modport slave (
    input  i_ibus_cyc, i_ibus_adr,
    output o_ibus_rdt, o_ibus_ack,
    input  i_dbus_cyc, i_dbus_adr, i_dbus_we, i_dbus_dat, i_dbus_sel,
    output o_dbus_rdt, o_dbus_ack,
    input  i_h_valid, i_h_we, i_h_addr, i_h_wdata,
    output o_h_rdata, o_h_ready,
    output o_ram_en, o_ram_a, o_ram_we, o_ram_di,
    input  i_ram_do
  );

  modport master (
    output i_ibus_cyc, i_ibus_adr,
    input  o_ibus_rdt, o_ibus_ack,
    output i_dbus_cyc, i_dbus_adr, i_dbus_we, i_dbus_dat, i_dbus_sel,
    input  o_dbus_rdt, o_dbus_ack,
    output i_h_valid, i_h_we, i_h_addr, i_h_wdata,
    input  o_h_rdata, o_h_ready,
    input  o_ram_en, o_ram_a, o_ram_we, o_ram_di,
    output i_ram_do
  );

endinterface

// File: rtl/wb_ram_grant.sv
// Combinational grant selection for the three RAM requesters.
// Ports:
//   i_req  - request vector indexed by grant_e
//   i_ptr  - round-robin pointer, present only when WB_RAM_RR_EN is defined
//   o_gnt  - one-hot grant, zero when nothing requests
// Build option WB_RAM_RR_EN: round-robin starting at i_ptr; otherwise fixed
// priority host > dbus > ibus.
module wb_ram_grant
  import wb_ram_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
`ifdef WB_RAM_RR_EN
  input  grant_e           i_ptr,
`endif
  output logic [N_REQ-1:0] o_gnt
);

`ifdef WB_RAM_RR_EN
  logic [1:0] idx;

  // Walk the ring from the pointer; the first active request wins.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    o_gnt = '0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = 2'((int'(i_ptr) + k) % N_REQ);
      if (o_gnt == '0 && i_req[idx]) o_gnt[idx] = 1'b1;
    end
  end
`else
  always_comb begin
    o_gnt = '0;
    if      (i_req[G_HOST]) o_gnt[G_HOST] = 1'b1;
    else if (i_req[G_DBUS]) o_gnt[G_DBUS] = 1'b1;
    else if (i_req[G_IBUS]) o_gnt[G_IBUS] = 1'b1;
  end
`endif

endmodule

// File: rtl/wb_ram_arbiter.sv
// Shares one single-port byte-masked RAM macro among SERV ibus, SERV dbus and
// a host byte port. Each access runs IDLE -> ISSUE -> WAIT -> DONE; the RAM
// enable is high only in ISSUE, read data is captured in DONE and the ack
// pulse plus read data are registered, so the ack appears RD_LAT+2 cycles
// after the request is first seen in IDLE.
// Ports:
//   clk   - clock
//   i_rst - synchronous reset, active high
//   bus   - wb_ram_arbiter_if.slave: requester buses and RAM macro signals
// Parameters: DW data width, AW RAM word-address bits, RD_LAT RAM latency 1..3.
// Build option WB_RAM_RR_EN: round-robin arbitration (default fixed priority).
module wb_ram_arbiter
  import wb_ram_pkg::*;
#(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int RD_LAT = 1
) (
  input logic              clk,
  input logic              i_rst,
  wb_ram_arbiter_if.slave  bus
);

  localparam int NB = DW / 8;
  localparam int LB = lane_bits(DW);

  state_e           state_q, state_d;
  grant_e           gnt_q, gnt_d;
  logic [AW-1:0]    adr_q, adr_d;
  logic [NB-1:0]    we_q, we_d;
  logic [DW-1:0]    di_q, di_d;
  logic [LB-1:0]    lane_q, lane_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             ibus_ack_q, ibus_ack_d;
  logic [DW-1:0]    ibus_rdt_q, ibus_rdt_d;
  logic             dbus_ack_q, dbus_ack_d;
  logic [DW-1:0]    dbus_rdt_q, dbus_rdt_d;
  logic             h_ready_q, h_ready_d;
  logic [7:0]       h_rdata_q, h_rdata_d;
`ifdef WB_RAM_RR_EN
  grant_e           ptr_q, ptr_d;
`endif

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;

  always_comb begin
    req         = '0;
    req[G_HOST] = bus.i_h_valid;
    req[G_DBUS] = bus.i_dbus_cyc;
    req[G_IBUS] = bus.i_ibus_cyc;
  end

  wb_ram_grant u_grant (
    .i_req (req),
`ifdef WB_RAM_RR_EN
    .i_ptr (ptr_q),
`endif
    .o_gnt (gnt)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    adr_d      = adr_q;
    we_d       = we_q;
    di_d       = di_q;
    lane_d     = lane_q;
    cnt_d      = cnt_q;
    ibus_ack_d = 1'b0;
    ibus_rdt_d = ibus_rdt_q;
    dbus_ack_d = 1'b0;
    dbus_rdt_d = dbus_rdt_q;
    h_ready_d  = 1'b0;
    h_rdata_d  = h_rdata_q;
`ifdef WB_RAM_RR_EN
    ptr_d      = ptr_q;
`endif

    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = ISSUE;
          cnt_d   = '0;
          we_d    = '0;
          if (gnt[G_HOST]) begin
            gnt_d  = G_HOST;
            adr_d  = bus.i_h_addr[AW+LB-1:LB];
            lane_d = bus.i_h_addr[LB-1:0];
            di_d   = {NB{bus.i_h_wdata}};
            if (bus.i_h_we) we_d[bus.i_h_addr[LB-1:0]] = 1'b1;
          end else if (gnt[G_DBUS]) begin
            gnt_d = G_DBUS;
            adr_d = bus.i_dbus_adr[AW+1:2];
            di_d  = bus.i_dbus_dat;
            // A zero byte mask still runs a (write-less) RAM cycle and acks.
            if (bus.i_dbus_we) we_d = bus.i_dbus_sel;
          end else begin
            gnt_d = G_IBUS;
            adr_d = bus.i_ibus_adr[AW+1:2];
          end
`ifdef WB_RAM_RR_EN
          ptr_d = next_grant(gnt_d);
`endif
        end
      end
      ISSUE: state_d = (RD_LAT == 1) ? DONE : WAIT;
      WAIT: begin
        // WAIT spans RD_LAT-1 cycles so DONE lines up with valid i_ram_do.
        if (cnt_q == 2'(RD_LAT - 2)) state_d = DONE;
        else                         cnt_d   = cnt_q + 2'd1;
      end
      DONE: begin
        state_d = IDLE;
        // A requester that dropped its request mid-access gets no ack.
        case (gnt_q)
          G_HOST: if (bus.i_h_valid) begin
            h_ready_d = 1'b1;
            h_rdata_d = bus.i_ram_do[{lane_q, 3'b000} +: 8];
          end
          G_DBUS: if (bus.i_dbus_cyc) begin
            dbus_ack_d = 1'b1;
            dbus_rdt_d = bus.i_ram_do;
          end
          default: if (bus.i_ibus_cyc) begin
            ibus_ack_d = 1'b1;
            ibus_rdt_d = bus.i_ram_do;
          end
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (i_rst) begin
      state_q    <= IDLE;
      gnt_q      <= G_HOST;
      adr_q      <= '0;
      we_q       <= '0;
      di_q       <= '0;
      lane_q     <= '0;
      cnt_q      <= '0;
      ibus_ack_q <= 1'b0;
      ibus_rdt_q <= '0;
      dbus_ack_q <= 1'b0;
      dbus_rdt_q <= '0;
      h_ready_q  <= 1'b0;
      h_rdata_q  <= '0;
`ifdef WB_RAM_RR_EN
      ptr_q      <= G_HOST;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      adr_q      <= adr_d;
      we_q       <= we_d;
      di_q       <= di_d;
      lane_q     <= lane_d;
      cnt_q      <= cnt_d;
      ibus_ack_q <= ibus_ack_d;
      ibus_rdt_q <= ibus_rdt_d;
      dbus_ack_q <= dbus_ack_d;
      dbus_rdt_q <= dbus_rdt_d;
      h_ready_q  <= h_ready_d;
      h_rdata_q  <= h_rdata_d;
`ifdef WB_RAM_RR_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  assign bus.o_ram_en   = (state_q == ISSUE);
  assign bus.o_ram_we   = (state_q == ISSUE) ? we_q : '0;
  assign bus.o_ram_a    = adr_q;
  assign bus.o_ram_di   = di_q;
  assign bus.o_ibus_ack = ibus_ack_q;
  assign bus.o_ibus_rdt = ibus_rdt_q;
  assign bus.o_dbus_ack = dbus_ack_q;
  assign bus.o_dbus_rdt = dbus_rdt_q;
  assign bus.o_h_ready  = h_ready_q;
  assign bus.o_h_rdata  = h_rdata_q;

  // CPU address bits outside the word index are ignored, so the space aliases.
  logic unused_adr_bits;
  assign unused_adr_bits = ^{bus.i_ibus_adr[31:AW+2], bus.i_ibus_adr[1:0],
                             bus.i_dbus_adr[31:AW+2], bus.i_dbus_adr[1:0]};

endmodule
